// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the AES request scheduler.
package aes_sched_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} sched_state_t;

  // Width of a requester index, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts just after last_grant
// and wraps, so the most recently served requester has the lowest priority.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    // NOTE: every variable written here gets a default first, so no path through the loop can infer a latch.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/aes_req_sched.sv
// Round-robin sequencer in front of an AES core: accepts one request at a
// time, runs it on the core under a watchdog and returns the result.
module aes_req_sched
  import aes_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64,
  parameter int ID_W    = id_width(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*AES_BLK_W-1:0]   req_key,
  input  logic [N_REQ*AES_BLK_W-1:0]   req_text,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [AES_BLK_W-1:0]         resp_data,
  output logic                         resp_err,
  output logic                         busy,
  output logic                         core_rst,
  output logic                         core_ld,
  output logic [AES_BLK_W-1:0]         core_key,
  output logic [AES_BLK_W-1:0]         core_text_in,
  input  logic                         core_done,
  input  logic [AES_BLK_W-1:0]         core_text_out
);

  localparam int              CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(N_REQ - 1);

  sched_state_t          state_q, state_d;
  logic [ID_W-1:0]       last_grant_q;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       id_q;
  logic [N_REQ-1:0]      grant;
  logic [CNT_W-1:0]      wd_cnt_q;
  logic [AES_BLK_W-1:0]  key_q, text_q, data_q;
  logic                  err_q;
  logic                  core_rst_q;
  logic                  arb_en;
  logic                  accept;
  logic                  done_hit;
  logic                  abort;

  // Gating with rst keeps req_ready low for the whole reset window.
  assign arb_en = rst && (state_q == IDLE);

  rr_arbiter #(
    .N    (N_REQ),
    .IDX_W(ID_W)
  ) u_arb (
    .req       (req_valid),
    .last_grant(last_grant_q),
    .en        (arb_en),
    .gnt       (grant),
    .idx       (grant_idx)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    done_hit = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = BUSY;
      BUSY: begin
        // A done arriving on the last watchdog cycle still counts as success.
        if (core_done) begin
          done_hit = 1'b1;
          state_d  = RESP;
        end else if (wd_cnt_q == CNT_LAST) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every always_ff sees the pre-edge value.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the wide key/text/result registers are cleared as well so no stale ciphertext leaks out after reset.
      last_grant_q <= LAST_INIT;
      id_q         <= '0;
      key_q        <= '0;
      text_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      wd_cnt_q     <= '0;
      core_rst_q   <= 1'b0;
    end else begin
      core_rst_q <= !abort;
      if (accept) begin
        last_grant_q <= grant_idx;
        id_q         <= grant_idx;
        key_q        <= req_key[int'(grant_idx)*AES_BLK_W +: AES_BLK_W];
        text_q       <= req_text[int'(grant_idx)*AES_BLK_W +: AES_BLK_W];
      end
      if (state_q == LOAD)      wd_cnt_q <= '0;
      else if (state_q == BUSY) wd_cnt_q <= wd_cnt_q + CNT_W'(1);
      if (done_hit) begin
        data_q <= core_text_out;
        err_q  <= 1'b0;
      end else if (abort) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  assign req_ready    = grant;
  assign resp_valid   = (state_q == RESP);
  assign resp_id      = id_q;
  assign resp_data    = data_q;
  assign resp_err     = err_q;
  assign busy         = (state_q != IDLE);
  assign core_ld      = (state_q == LOAD);
  assign core_rst     = core_rst_q;
  assign core_key     = key_q;
  assign core_text_in = text_q;

  assert property (@(posedge clk) disable iff (!rst) $onehot0(req_ready));
  assert property (@(posedge clk) disable iff (!rst)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_data) && $stable(resp_id) && $stable(resp_err)));

endmodule

// File: tb/tb_aes_req_sched.sv
// Bench for aes_req_sched: a transaction-timeline model predicts every output
// each cycle while directed scenarios and random traffic drive the design.
`timescale 1ns/1ps
module tb_aes_req_sched;

  localparam int N  = 2;
  localparam int TO = 16;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*128-1:0] req_key;
  logic [N*128-1:0] req_text;
  logic             resp_valid;
  logic             resp_ready;
  logic [0:0]       resp_id;
  logic [127:0]     resp_data;
  logic             resp_err;
  logic             busy;
  logic             core_rst;
  logic             core_ld;
  logic [127:0]     core_key;
  logic [127:0]     core_text_in;
  logic             core_done = 1'b0;
  logic [127:0]     core_text_out = '0;

  always #5 clk = ~clk;

  aes_req_sched #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_key      (req_key),
    .req_text     (req_text),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .busy         (busy),
    .core_rst     (core_rst),
    .core_ld      (core_ld),
    .core_key     (core_key),
    .core_text_in (core_text_in),
    .core_done    (core_done),
    .core_text_out(core_text_out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Stand-in for the cipher: the known test vector, otherwise a keyed mix.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
    if (k == K0 && t == P0) return C0;
    return {k[63:0], k[127:64]} ^ t ^ 128'h5a5a_0ff0_c3c3_1234_a5a5_f00f_3c3c_4321;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core model: done pulses core_delay cycles after the load (0 = never).
  int           core_delay = 0;
  int           cd = 0;
  logic [127:0] cm_key, cm_text;

  always @(negedge clk) begin
    core_done     = 1'b0;
    core_text_out = rand128();
    if (core_rst !== 1'b1) cd = 0;
    else if (core_ld === 1'b1) begin
      cd      = core_delay;
      cm_key  = core_key;
      cm_text = core_text_in;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        core_done     = 1'b1;
        core_text_out = core_fn(cm_key, cm_text);
      end
    end
  end

  // Requester and consumer stimulus state.
  bit           rv[N];
  logic [127:0] rk[N];
  logic [127:0] rt[N];
  bit           rr_in;
  bit           rst_in;
  bit           refill;
  int           next_delay;

  // Reference model: one transaction described by its event cycles.
  bit           m_act;
  int           m_id;
  logic [127:0] m_key, m_text, m_data;
  bit           m_err;
  int           m_ld_cyc, m_resp_cyc;
  int           m_last;
  bit           m_prev_rst_low;
  int           cyc;
  bit           chk_en;
  int           n_acc;

  typedef struct {
    int           id;
    logic [127:0] data;
    logic         err;
  } resp_t;

  int    obs_grants[$];
  resp_t obs_resp[$];

  function automatic int model_pick();
    if (m_act) return -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (rv[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit any_rv();
    for (int i = 0; i < N; i++) if (rv[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_cycle();
    logic [N-1:0] exp_ready;
    int           g, obs_g;
    bit           exp_rv, exp_ld, exp_crst;
    resp_t        r;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = rv[i];
      req_key[128*i +: 128]  = rk[i];
      req_text[128*i +: 128] = rt[i];
    end
    resp_ready = rr_in;
    rst        = rst_in;
    g          = model_pick();
    exp_ready  = '0;
    if (rst_in && g >= 0) exp_ready[g] = 1'b1;
    exp_rv   = m_act && (cyc >= m_resp_cyc);
    exp_ld   = m_act && (cyc == m_ld_cyc);
    exp_crst = !(m_prev_rst_low || (m_act && m_err && cyc == m_resp_cyc));
    @(negedge clk);
    if (chk_en) begin
      check("req_ready", req_ready, exp_ready);
      check("ready_onehot0", $countones(req_ready) <= 1, 1);
      check("busy", busy, m_act);
      check("core_ld", core_ld, exp_ld);
      check("core_rst", core_rst, exp_crst);
      check("resp_valid", resp_valid, exp_rv);
      if (m_act) begin
        check("core_key", core_key, m_key);
        check("core_text_in", core_text_in, m_text);
      end
      if (exp_rv) begin
        check("resp_id", resp_id, m_id);
        check("resp_data", resp_data, m_data);
        check("resp_err", resp_err, m_err);
      end
    end
    obs_g = -1;
    for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) obs_g = i;
    if (!rst_in) begin
      m_act          = 1'b0;
      m_last         = N - 1;
      m_prev_rst_low = 1'b1;
    end else begin
      m_prev_rst_low = 1'b0;
      if (g >= 0) begin
        m_act      = 1'b1;
        m_id       = g;
        m_key      = rk[g];
        m_text     = rt[g];
        m_ld_cyc   = cyc + 1;
        m_last     = g;
        core_delay = next_delay;
        if (next_delay >= 1 && next_delay <= TO) begin
          m_resp_cyc = m_ld_cyc + next_delay + 1;
          m_data     = core_fn(m_key, m_text);
          m_err      = 1'b0;
        end else begin
          m_resp_cyc = m_ld_cyc + TO + 1;
          m_data     = '0;
          m_err      = 1'b1;
        end
        obs_grants.push_back(obs_g);
        n_acc++;
        if (refill) begin
          rk[g] = rand128();
          rt[g] = rand128();
        end else rv[g] = 1'b0;
      end else if (exp_rv && rr_in) begin
        r.id   = int'(resp_id);
        r.data = resp_data;
        r.err  = resp_err;
        obs_resp.push_back(r);
        m_act = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input string tag, input int max);
    int n;
    n = 0;
    while ((m_act || any_rv()) && n < max) begin
      run_cycle();
      n++;
    end
    check(tag, n < max, 1);
  endtask

  task automatic issue(input int i, input logic [127:0] k, input logic [127:0] t);
    rv[i] = 1'b1;
    rk[i] = k;
    rt[i] = t;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start, n, base;
    rst_in = 1'b0; rr_in = 1'b1; refill = 1'b0; next_delay = 5;
    for (int i = 0; i < N; i++) begin rv[i] = 1'b0; rk[i] = '0; rt[i] = '0; end
    m_act = 1'b0; m_last = N - 1; m_prev_rst_low = 1'b1; cyc = 0; chk_en = 1'b0; n_acc = 0;
    m_id = 0; m_key = '0; m_text = '0; m_data = '0; m_err = 1'b0; m_ld_cyc = 0; m_resp_cyc = 0;

    // Reset: outputs zero, core_rst low.
    run_cycle();
    chk_en = 1'b1;
    run_cycle();
    check("rst_resp_data", resp_data, 0);
    check("rst_core_key", core_key, 0);
    run_cycle();
    rst_in = 1'b1;
    run_cycle();

    // Single request with the known vector, done 11 cycles after load.
    issue(0, K0, P0);
    next_delay = 11;
    run_until_idle("t1_bound", 60);
    check("t1_data", (obs_resp.size() > 0) ? obs_resp[$].data : '0, C0);
    check("t1_id", (obs_resp.size() > 0) ? obs_resp[$].id : -1, 0);
    issue(1, rand128(), rand128());
    next_delay = 2;
    run_until_idle("t1b_bound", 40);

    // Contention: both requesters continuously valid.
    obs_grants.delete();
    obs_resp.delete();
    refill = 1'b1;
    issue(0, rand128(), rand128());
    issue(1, rand128(), rand128());
    next_delay = 4;
    start = n_acc;
    for (int c = 0; c < 100 && n_acc < start + 4; c++) run_cycle();
    refill = 1'b0;
    run_until_idle("t2_bound", 100);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_grant%0d", i), (i < obs_grants.size()) ? obs_grants[i] : -1, i % 2);
      check($sformatf("t2_resp_id%0d", i), (i < obs_resp.size()) ? obs_resp[i].id : -1, i % 2);
    end

    // Backpressure with req1 pending.
    rr_in = 1'b0;
    issue(0, rand128(), rand128());
    issue(1, rand128(), rand128());
    next_delay = 3;
    n = 0;
    while (!(m_act && cyc >= m_resp_cyc) && n < 50) begin run_cycle(); n++; end
    check("t3_resp_bound", n < 50, 1);
    for (int c = 0; c < 5; c++) run_cycle();
    rr_in = 1'b1;
    run_cycle();
    run_cycle();
    check("t3_next_grant", (obs_grants.size() > 0) ? obs_grants[$] : -1, 1);
    run_until_idle("t3_bound", 60);

    // Watchdog abort, then a normal transaction.
    issue(0, rand128(), rand128());
    next_delay = 0;
    run_until_idle("t4_bound", 60);
    check("t4_err", (obs_resp.size() > 0) ? obs_resp[$].err : 1'b0, 1);
    check("t4_data", (obs_resp.size() > 0) ? obs_resp[$].data : '1, 0);
    issue(1, rand128(), rand128());
    next_delay = 7;
    run_until_idle("t4b_bound", 60);
    check("t4b_err", (obs_resp.size() > 0) ? obs_resp[$].err : 1'b1, 0);

    // Done on the final watchdog cycle.
    issue(0, rand128(), rand128());
    next_delay = TO;
    run_until_idle("t5_bound", 60);
    check("t5_err", (obs_resp.size() > 0) ? obs_resp[$].err : 1'b1, 0);
    check("t5_data", (obs_resp.size() > 0) ? obs_resp[$].data : '0, core_fn(m_key, m_text));

    // Reset while BUSY drops the operation; req0 is first afterwards.
    issue(0, rand128(), rand128());
    next_delay = 0;
    for (int c = 0; c < 5; c++) run_cycle();
    rst_in = 1'b0;
    issue(0, rand128(), rand128());
    issue(1, rand128(), rand128());
    base = obs_resp.size();
    run_cycle();
    #1;
    check("t6_req_ready", req_ready, 0);
    check("t6_resp_valid", resp_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_core_rst", core_rst, 0);
    check("t6_core_ld", core_ld, 0);
    check("t6_resp_data", resp_data, 0);
    check("t6_resp_err", resp_err, 0);
    check("t6_core_key", core_key, 0);
    run_cycle();
    check("t6_no_resp", obs_resp.size(), base);
    rst_in = 1'b1;
    n = obs_grants.size();
    run_until_idle("t6_bound", 100);
    check("t6_first_grant", (n < obs_grants.size()) ? obs_grants[n] : -1, 0);

    // Randomized traffic with mixed delays, timeouts and backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(0, 3) == 0) issue(i, rand128(), rand128());
      rr_in = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       next_delay = 0;
        1:       next_delay = $urandom_range(17, 20);
        2:       next_delay = TO;
        default: next_delay = $urandom_range(1, 8);
      endcase
      run_cycle();
    end
    rr_in = 1'b1;
    run_until_idle("rand_drain", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_req_sched.md
Name: aes_req_sched

Overview:
Sequencer and arbiter placed in front of the AES core.
- Accepts encrypt requests (key + plaintext) from N_REQ independent requesters over valid/ready handshakes.
- Grants one requester at a time by round-robin, drives the core's ld/key/text_in, and waits for done.
- Returns text_out to the granted requester with its id.
- A watchdog aborts a hung operation, resets the core and returns an error response.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- TIMEOUT, 64, maximum BUSY cycles to wait for core_done before abort (>=2).
- ID_W, $clog2(N_REQ) (min 1), width of resp_id.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; at most one bit high.
- req_key  input  N_REQ*128  packed keys; requester i at [128*i +: 128].
- req_text  input  N_REQ*128  packed plaintexts, same packing.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  ID_W  index of the requester this response belongs to.
- resp_data  output  128  ciphertext; 0 on error.
- resp_err  output  1  1 = watchdog abort.
- busy  output  1  high in any state other than IDLE.
- core_rst  output  1  active-low reset to the AES core; registered.
- core_ld  output  1  one-cycle load strobe to the core.
- core_key  output  128  key to the core; held stable from LOAD until return to IDLE.
- core_text_in  output  128  plaintext to the core; held like core_key.
- core_done  input  1  completion pulse from the core.
- core_text_out  input  128  core result; valid when core_done is high.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; all outputs 0 except core_rst, which is 0 while rst=0 and 1 on the first cycle after rst returns high.
  - last_grant=N_REQ-1, so requester 0 has top priority first.
  - Watchdog counter=0; latched key/text/id cleared.
  - Reset mid-operation drops the in-flight request with no response.
- States: IDLE -> LOAD -> BUSY -> RESP -> IDLE.
- IDLE:
  - Round-robin search starts at (last_grant+1) mod N_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1 combinationally in the same cycle.
  - That cycle: latch key/text/id, set last_grant=i, go to LOAD.
  - With no valid request, stay in IDLE.
  - req_ready is 0 in every other state.
- LOAD: core_ld=1 for exactly this cycle with the latched key/text; counter=0; go to BUSY. core_done during LOAD is ignored (stale).
- BUSY:
  - Counter increments each cycle.
  - core_done=1: latch core_text_out, resp_err=0, go to RESP.
  - Counter==TIMEOUT-1 with core_done=0: resp_data=0, resp_err=1, core_rst=0 for the next cycle, go to RESP.
  - core_done and timeout in the same cycle: done wins, no abort.
- RESP:
  - resp_valid=1; resp_id/resp_data/resp_err held stable until the cycle with resp_ready=1, then go to IDLE.
  - No new grant while in RESP.
  - core_done pulses arriving in RESP are ignored.
- Latency: accept at cycle N -> core_ld at N+1 -> resp_valid at done cycle + 1.
  - Minimum accept-to-next-accept is 4 cycles when resp_ready=1.
- Requesters hold req_valid, req_key and req_text stable until their ready.
  - Correct operation does not depend on this; data is sampled only in the accept cycle.
- N_REQ=1 degenerates to a single-requester sequencer; resp_id is always 0.

Decomposition:
- Package aes_sched_pkg:
  - AES_BLK_W=128;
  - typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} sched_state_t;
  - a function computing ID_W with minimum 1.
- Sub-module rr_arbiter (N parameter):
  - inputs: request vector, last_grant, enable;
  - outputs: one-hot grant and encoded index;
  - purely combinational; the last_grant register lives in aes_req_sched.

Test Plan:
1. Single request.
   - Stimulus: req0 key=000102030405060708090a0b0c0d0e0f, text=00112233445566778899aabbccddeeff, core model done after 11 cycles.
   - Required: core_ld exactly 1 cycle after accept; resp_valid with resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, id=0, err=0.
2. Contention.
   - Stimulus: req0 and req1 held valid continuously for 4 transactions.
   - Required: grants alternate 0,1,0,1; resp_id sequence 0,1,0,1; req_ready never two bits high.
3. Backpressure.
   - Stimulus: resp_ready=0 for 5 cycles after resp_valid while req1 is pending.
   - Required: resp_data/resp_id/resp_err stable; req_ready=0 throughout; req1 is accepted in the cycle after resp_ready=1.
4. Timeout.
   - Stimulus: TIMEOUT=16, core never asserts done.
   - Required: resp_err=1 and resp_data=0 exactly 16 BUSY cycles after LOAD; core_rst=0 for exactly 1 cycle; the next request completes normally.
5. Done coinciding with timeout.
   - Stimulus: core_done asserted in BUSY cycle 16 with TIMEOUT=16.
   - Required: resp_err=0, data is the core value, core_rst stays 1.
6. Reset mid-BUSY.
   - Stimulus: rst=0 for 2 cycles during BUSY.
   - Required: no response emitted; all outputs 0 while in reset; after release req0 is granted first.
